// File: rtl/writeback_pkg.sv
// ============================================================================
// writeback_pkg : kind encodings, queue-entry control struct, pointer helper
// Revision      : 1.0
// ============================================================================
`default_nettype none

package writeback_pkg;

    typedef enum logic [1:0] {
        WB_NOP = 2'd0,
        WB_ALU = 2'd1,
        WB_CMP = 2'd2,
        WB_LD  = 2'd3
    } wb_kind_e;

    // Control part of a queue entry; the width-parametrised payload (rd, result,
    // cpsr) lives in parallel arrays sized by the instantiating module.
    typedef struct packed {
        wb_kind_e kind;
        logic     set_flags;
        logic     data_ok;
    } wb_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/retire_queue.sv
// ============================================================================
// retire_queue : in-order entry storage with head/tail/fill tracking
// Revision     : 1.0
// ============================================================================
`default_nettype none

module retire_queue
    import writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  wb_kind_e                   enq_kind,
    input  logic                       enq_set_flags,
    input  logic [REG_W-1:0]           enq_rd,
    input  logic [DATA_W-1:0]          enq_result,
    input  logic [DATA_W-1:0]          enq_cpsr,
    input  logic                       fill,
    input  logic [DATA_W-1:0]          fill_data,
    input  logic                       pop,
    output logic                       fill_avail,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] ld_pending,
    output logic                       head_valid,
    output logic                       head_ok,
    output wb_kind_e                   head_kind,
    output logic                       head_set_flags,
    output logic [REG_W-1:0]           head_rd,
    output logic [DATA_W-1:0]          head_result,
    output logic [DATA_W-1:0]          head_cpsr
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t         ctrl_q   [DEPTH];
    logic [REG_W-1:0]  rd_q     [DEPTH];
    logic [DATA_W-1:0] result_q [DEPTH];
    logic [DATA_W-1:0] cpsr_q   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill_idx;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] pend_q;
    logic             enq_ld;

    // Fill pointer: oldest occupied entry still waiting for data. Only loads
    // enqueue with data_ok=0, so this is the oldest unfilled load.
    always_comb begin
        fill_idx   = '0;
        fill_avail = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!fill_avail && (CNT_W'(k) < count_q) &&
                !ctrl_q[head + PTR_W'(k)].data_ok) begin
                fill_avail = 1'b1;
                fill_idx   = head + PTR_W'(k);
            end
        end
    end

    assign enq_ld = enq && (enq_kind == WB_LD);

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
            pend_q  <= pend_q + CNT_W'(enq_ld) - CNT_W'(fill);
        end
    end

    // Enqueue and fill never target the same slot: the tail is unoccupied.
    always_ff @(posedge clk) begin
        if (enq) begin
            ctrl_q[tail]   <= '{kind: enq_kind, set_flags: enq_set_flags,
                                data_ok: (enq_kind != WB_LD)};
            rd_q[tail]     <= enq_rd;
            result_q[tail] <= enq_result;
            cpsr_q[tail]   <= enq_cpsr;
        end
        if (fill) begin
            result_q[fill_idx]       <= fill_data;
            ctrl_q[fill_idx].data_ok <= 1'b1;
        end
    end

    assign count          = count_q;
    assign ld_pending     = pend_q;
    assign head_valid     = (count_q != '0);
    assign head_ok        = ctrl_q[head].data_ok;
    assign head_kind      = ctrl_q[head].kind;
    assign head_set_flags = ctrl_q[head].set_flags;
    assign head_rd        = rd_q[head];
    assign head_result    = result_q[head];
    assign head_cpsr      = cpsr_q[head];

endmodule

`default_nettype wire

// File: rtl/writeback_queue.sv
// ============================================================================
// writeback_queue : in-order writeback with late load data and CPSR strobes
// Revision        : 1.0
// ============================================================================
`default_nettype none

module writeback_queue
    import writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_kind,
    input  logic                       in_set_flags,
    input  logic [REG_W-1:0]           in_rd,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [DATA_W-1:0]          in_cpsr,
    input  logic                       dmem_rsp_valid,
    input  logic [DATA_W-1:0]          dmem_rsp_data,
    output logic                       rd_write_en,
    output logic [REG_W-1:0]           rd_num,
    output logic [DATA_W-1:0]          rd_val,
    output logic                       cpsr_write_en,
    output logic [DATA_W-1:0]          cpsr_out,
    output logic                       retire_valid,
    output logic [$clog2(DEPTH+1)-1:0] ld_pending,
    output logic                       rsp_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              enq;
    logic              pop;
    logic              fill;
    logic              fill_avail;
    logic [CNT_W-1:0]  count;
    logic              head_valid;
    logic              head_ok;
    wb_kind_e          head_kind;
    logic              head_set_flags;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_result;
    logic [DATA_W-1:0] head_cpsr;
    logic              wr_rd;
    logic              wr_cpsr;

    // Ready comes from the registered count only; a same-cycle pop is ignored.
    assign in_ready = (count < CNT_W'(DEPTH));
    assign enq      = in_valid && in_ready;
    assign fill     = dmem_rsp_valid && fill_avail;
    assign pop      = head_valid && head_ok;
    assign wr_rd    = pop && ((head_kind == WB_ALU) || (head_kind == WB_LD));
    assign wr_cpsr  = pop && ((head_kind == WB_CMP) ||
                              ((head_kind == WB_ALU) && head_set_flags));

    retire_queue #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (DEPTH)
    ) u_retire_queue (
        .clk            (clk),
        .rst            (rst),
        .enq            (enq),
        .enq_kind       (wb_kind_e'(in_kind)),
        .enq_set_flags  (in_set_flags),
        .enq_rd         (in_rd),
        .enq_result     (in_result),
        .enq_cpsr       (in_cpsr),
        .fill           (fill),
        .fill_data      (dmem_rsp_data),
        .pop            (pop),
        .fill_avail     (fill_avail),
        .count          (count),
        .ld_pending     (ld_pending),
        .head_valid     (head_valid),
        .head_ok        (head_ok),
        .head_kind      (head_kind),
        .head_set_flags (head_set_flags),
        .head_rd        (head_rd),
        .head_result    (head_result),
        .head_cpsr      (head_cpsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_valid  <= 1'b0;
            rd_write_en   <= 1'b0;
            cpsr_write_en <= 1'b0;
            rd_num        <= '0;
            rd_val        <= '0;
            cpsr_out      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            retire_valid  <= pop;
            rd_write_en   <= wr_rd;
            cpsr_write_en <= wr_cpsr;
            if (wr_rd) begin
                rd_num <= head_rd;
                rd_val <= head_result;
            end
            if (wr_cpsr) cpsr_out <= head_cpsr;
            if (dmem_rsp_valid && !fill_avail) rsp_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue.sv
// ============================================================================
// tb_writeback_queue : directed self-checking bench for writeback_queue
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_queue;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic              in_set_flags;
    logic [REG_W-1:0]  in_rd;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_cpsr;
    logic              dmem_rsp_valid;
    logic [DATA_W-1:0] dmem_rsp_data;
    logic              rd_write_en;
    logic [REG_W-1:0]  rd_num;
    logic [DATA_W-1:0] rd_val;
    logic              cpsr_write_en;
    logic [DATA_W-1:0] cpsr_out;
    logic              retire_valid;
    logic [2:0]        ld_pending;
    logic              rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    writeback_queue #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kind        (in_kind),
        .in_set_flags   (in_set_flags),
        .in_rd          (in_rd),
        .in_result      (in_result),
        .in_cpsr        (in_cpsr),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_data  (dmem_rsp_data),
        .rd_write_en    (rd_write_en),
        .rd_num         (rd_num),
        .rd_val         (rd_val),
        .cpsr_write_en  (cpsr_write_en),
        .cpsr_out       (cpsr_out),
        .retire_valid   (retire_valid),
        .ld_pending     (ld_pending),
        .rsp_err        (rsp_err)
    );

    always #5 clk = ~clk;

    // Strobe vector order everywhere below: {rd_write_en, cpsr_write_en, retire_valid}
    task automatic idle();
        in_valid       = 1'b0;
        in_kind        = 2'd0;
        in_set_flags   = 1'b0;
        in_rd          = '0;
        in_result      = '0;
        in_cpsr        = '0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data  = '0;
    endtask

    task automatic drive_in(input logic [1:0] k, input logic sf, input logic [3:0] rd,
                            input logic [31:0] res, input logic [31:0] cp);
        in_valid     = 1'b1;
        in_kind      = k;
        in_set_flags = sf;
        in_rd        = rd;
        in_result    = res;
        in_cpsr      = cp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid} !== 3'b000) begin n_fail++;
            $display("FAIL reset_strobes: got %b expected 000", {rd_write_en, cpsr_write_en, retire_valid}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if ({rd_num, rd_val, cpsr_out} !== '0) begin n_fail++;
            $display("FAIL reset_outputs: got rd_num=%h rd_val=%h cpsr=%h expected zeros", rd_num, rd_val, cpsr_out); end
        n_cmp++; if (ld_pending !== 3'd0) begin n_fail++; $display("FAIL reset_ld_pending: got %0d expected 0", ld_pending); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    endtask

    task automatic test_alu_cmp();
        drive_in(2'd1, 1'b0, 4'd3, 32'h1234, 32'h0);
        @(negedge clk);
        drive_in(2'd2, 1'b0, 4'd0, 32'h0, 32'h6000_0000);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid} !== 3'b000) begin n_fail++;
            $display("FAIL alu_cmp_early: got %b expected 000", {rd_write_en, cpsr_write_en, retire_valid}); end
        @(negedge clk);
        idle();
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, rd_num, rd_val} !== {3'b101, 4'd3, 32'h1234}) begin n_fail++;
            $display("FAIL alu_retire: got strb=%b rd=%0d val=%h expected 101 3 1234",
                     {rd_write_en, cpsr_write_en, retire_valid}, rd_num, rd_val); end
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, cpsr_out} !== {3'b011, 32'h6000_0000}) begin n_fail++;
            $display("FAIL cmp_retire: got strb=%b cpsr=%h expected 011 60000000",
                     {rd_write_en, cpsr_write_en, retire_valid}, cpsr_out); end
        n_cmp++; if ({rd_num, rd_val} !== {4'd3, 32'h1234}) begin n_fail++;
            $display("FAIL rd_hold: got rd=%0d val=%h expected 3 1234", rd_num, rd_val); end
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid} !== 3'b000) begin n_fail++;
            $display("FAIL alu_cmp_idle: got %b expected 000", {rd_write_en, cpsr_write_en, retire_valid}); end
    endtask

    task automatic test_set_flags();
        drive_in(2'd1, 1'b1, 4'd5, 32'h55, 32'h8000_0000);
        @(negedge clk);
        idle();
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, rd_num, rd_val, cpsr_out} !==
                     {3'b111, 4'd5, 32'h55, 32'h8000_0000}) begin n_fail++;
            $display("FAIL set_flags: got strb=%b rd=%0d val=%h cpsr=%h expected 111 5 55 80000000",
                     {rd_write_en, cpsr_write_en, retire_valid}, rd_num, rd_val, cpsr_out); end
    endtask

    task automatic test_late_load();
        drive_in(2'd3, 1'b0, 4'd2, 32'h0, 32'h0);
        @(negedge clk);
        drive_in(2'd1, 1'b0, 4'd4, 32'h7, 32'h0);
        @(negedge clk);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, ld_pending} !== {3'b000, 3'd1}) begin n_fail++;
                $display("FAIL late_load_blocked[%0d]: got strb=%b pend=%0d expected 000 1",
                         i, {rd_write_en, cpsr_write_en, retire_valid}, ld_pending); end
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        idle();
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, ld_pending} !== {3'b000, 3'd0}) begin n_fail++;
            $display("FAIL late_load_fill: got strb=%b pend=%0d expected 000 0",
                     {rd_write_en, cpsr_write_en, retire_valid}, ld_pending); end
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, rd_num, rd_val} !== {3'b101, 4'd2, 32'hDEAD_BEEF}) begin n_fail++;
            $display("FAIL late_load_retire: got strb=%b rd=%0d val=%h expected 101 2 deadbeef",
                     {rd_write_en, cpsr_write_en, retire_valid}, rd_num, rd_val); end
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, rd_num, rd_val} !== {3'b101, 4'd4, 32'h7}) begin n_fail++;
            $display("FAIL late_load_younger: got strb=%b rd=%0d val=%h expected 101 4 7",
                     {rd_write_en, cpsr_write_en, retire_valid}, rd_num, rd_val); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL late_load_rsp_err: got %b expected 0", rsp_err); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive_in(2'd3, 1'b0, 4'(i + 1), 32'h0, 32'h0);
            @(negedge clk);
        end
        idle();
        n_cmp++; if ({in_ready, ld_pending} !== {1'b0, 3'd4}) begin n_fail++;
            $display("FAIL full_state: got ready=%b pend=%0d expected 0 4", in_ready, ld_pending); end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'h11;
        @(negedge clk);
        idle();
        n_cmp++; if ({in_ready, ld_pending, retire_valid} !== {1'b0, 3'd3, 1'b0}) begin n_fail++;
            $display("FAIL full_after_fill: got ready=%b pend=%0d ret=%b expected 0 3 0", in_ready, ld_pending, retire_valid); end
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, rd_num, rd_val, in_ready} !== {3'b101, 4'd1, 32'h11, 1'b1}) begin n_fail++;
            $display("FAIL full_first_retire: got strb=%b rd=%0d val=%h ready=%b expected 101 1 11 1",
                     {rd_write_en, cpsr_write_en, retire_valid}, rd_num, rd_val, in_ready); end
        for (int i = 0; i < 3; i++) begin
            dmem_rsp_valid = 1'b1;
            dmem_rsp_data  = 32'h22 + 32'(i) * 32'h11;
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, rd_num, rd_val, ld_pending} !== {3'b101, 4'd4, 32'h44, 3'd0}) begin n_fail++;
            $display("FAIL full_drain_last: got strb=%b rd=%0d val=%h pend=%0d expected 101 4 44 0",
                     {rd_write_en, cpsr_write_en, retire_valid}, rd_num, rd_val, ld_pending); end
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid} !== 3'b000) begin n_fail++;
            $display("FAIL full_drained_idle: got %b expected 000", {rd_write_en, cpsr_write_en, retire_valid}); end
    endtask

    task automatic test_back_to_back();
        drive_in(2'd1, 1'b0, 4'd8, 32'h80, 32'h0);
        @(negedge clk);
        drive_in(2'd1, 1'b0, 4'd9, 32'h90, 32'h0);
        @(negedge clk);
        n_cmp++; if ({rd_write_en, retire_valid, rd_num, rd_val} !== {2'b11, 4'd8, 32'h80}) begin n_fail++;
            $display("FAIL b2b_first: got we=%b ret=%b rd=%0d val=%h expected 1 1 8 80", rd_write_en, retire_valid, rd_num, rd_val); end
        drive_in(2'd0, 1'b0, 4'd10, 32'hA0, 32'h0);
        @(negedge clk);
        idle();
        n_cmp++; if ({rd_write_en, retire_valid, rd_num, rd_val} !== {2'b11, 4'd9, 32'h90}) begin n_fail++;
            $display("FAIL b2b_second: got we=%b ret=%b rd=%0d val=%h expected 1 1 9 90", rd_write_en, retire_valid, rd_num, rd_val); end
        @(negedge clk);
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, rd_num, rd_val} !== {3'b001, 4'd9, 32'h90}) begin n_fail++;
            $display("FAIL b2b_nop: got strb=%b rd=%0d val=%h expected 001 9 90",
                     {rd_write_en, cpsr_write_en, retire_valid}, rd_num, rd_val); end
    endtask

    task automatic test_rsp_err();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'h5;
        @(negedge clk);
        idle();
        n_cmp++; if ({rsp_err, rd_write_en, cpsr_write_en, retire_valid, ld_pending} !== {4'b1000, 3'd0}) begin n_fail++;
            $display("FAIL rsp_err_set: got err=%b strb=%b pend=%0d expected 1 000 0",
                     rsp_err, {rd_write_en, cpsr_write_en, retire_valid}, ld_pending); end
        repeat (3) @(negedge clk);
        n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL rsp_err_sticky: got %b expected 1", rsp_err); end
    endtask

    task automatic test_reset_midflight();
        drive_in(2'd3, 1'b0, 4'd1, 32'h0, 32'h0);
        @(negedge clk);
        drive_in(2'd1, 1'b0, 4'd6, 32'h99, 32'h0);
        @(negedge clk);
        drive_in(2'd1, 1'b1, 4'd7, 32'h77, 32'hF000_0000);
        @(negedge clk);
        idle();
        n_cmp++; if ({ld_pending, retire_valid} !== {3'd1, 1'b0}) begin n_fail++;
            $display("FAIL midflight_queued: got pend=%0d ret=%b expected 1 0", ld_pending, retire_valid); end
        rst            = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'hBAD;
        @(negedge clk);
        rst = 1'b0;
        idle();
        n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid, in_ready, ld_pending, rsp_err} !== {3'b000, 1'b1, 3'd0, 1'b0}) begin n_fail++;
            $display("FAIL midflight_ctrl: got strb=%b ready=%b pend=%0d err=%b expected 000 1 0 0",
                     {rd_write_en, cpsr_write_en, retire_valid}, in_ready, ld_pending, rsp_err); end
        n_cmp++; if ({rd_num, rd_val, cpsr_out} !== '0) begin n_fail++;
            $display("FAIL midflight_data: got rd=%0d val=%h cpsr=%h expected zeros", rd_num, rd_val, cpsr_out); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({rd_write_en, cpsr_write_en, retire_valid} !== 3'b000) begin n_fail++;
                $display("FAIL midflight_discard[%0d]: got %b expected 000", i, {rd_write_en, cpsr_write_en, retire_valid}); end
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'hC0DE;
        @(negedge clk);
        idle();
        n_cmp++; if ({rsp_err, rd_write_en, retire_valid} !== 3'b100) begin n_fail++;
            $display("FAIL midflight_stale_rsp: got err=%b we=%b ret=%b expected 1 0 0", rsp_err, rd_write_en, retire_valid); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_alu_cmp();
        test_set_flags();
        test_late_load();
        test_full();
        test_back_to_back();
        test_rsp_err();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
